mult_div_unit: RTL and testbench

Iterative multiply/divide unit that sits beside the single-cycle ALU in the execute stage and owns the HI/LO register pair. It executes R-type MULT, MULTU, DIV and DIVU over 32 iteration cycles using one internal 32-bit add/subtract step per cycle, and holds `busy` high so the control unit can stall the PC and pipeline. The datapath reads HI/LO directly for MFHI/MFLO once `busy` is low.

---
 rtl/mult_div_unit_if.sv | 31 +++
 rtl/mult_div_unit.sv | 129 ++++++++++++
 tb/tb_mult_div_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the execute-stage control and the
// multiply/divide unit.
//   start    : request strobe, sampled on the rising clock edge
//   funct    : R-type function field (MULT/MULTU/DIV/DIVU)
//   op_a     : rs value (multiplicand or dividend)
//   op_b     : rt value (multiplier or divisor)
//   busy     : operation in progress, pipeline must stall
//   done     : one-cycle pulse when hi/lo hold a new result
//   div_zero : high with done when a divide had op_b == 0
//   hi, lo   : HI/LO register pair
interface mult_div_unit_if;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, funct, op_a, op_b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, funct, op_a, op_b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO register pair.
// Executes MULT, MULTU, DIV and DIVU in 32 iteration cycles plus one
// sign-fix cycle, sharing a single add/subtract step between both ops.
//   clk   : clock, rising-edge
//   reset : asynchronous, active-high, clears all state
//   bus   : slave side of mult_div_unit_if (start/funct/op_a/op_b in,
//           busy/done/div_zero/hi/lo out)
module mult_div_unit (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [4:0]  cnt;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
  logic [63:0] acc;
  // Multiplicand for multiply, divisor for divide (magnitudes).
  logic [31:0] operand;
  logic [31:0] orig_a;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic        b_zero;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        valid_funct;
  logic        start_ok;
  logic        in_signed;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [33:0] alu_a;
  logic [33:0] alu_y;
  logic [63:0] prod_neg;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign valid_funct = (bus.funct[5:2] == 4'b0110);
  assign start_ok    = bus.start && valid_funct &&
                       ((state == S_IDLE) || (state == S_DONE));
  assign in_signed   = ~bus.funct[0];
  assign a_abs       = (in_signed && bus.op_a[31]) ? (~bus.op_a + 32'd1) : bus.op_a;
  assign b_abs       = (in_signed && bus.op_b[31]) ? (~bus.op_b + 32'd1) : bus.op_b;

  // Shared step: add for shift-add multiply, trial subtract for restoring
  // divide. Bit 33 is the borrow of the trial subtraction.
  always_comb begin
    alu_a = is_div ? {1'b0, acc[63:31]} : {2'b00, acc[63:32]};
    alu_y = is_div ? (alu_a - {2'b00, operand}) : (alu_a + {2'b00, operand});
  end

  always_comb begin
    prod_neg = ~acc + 64'd1;
    fix_hi   = '0;
    fix_lo   = '0;
    if (!is_div) begin
      fix_hi = neg_q ? prod_neg[63:32] : acc[63:32];
      fix_lo = neg_q ? prod_neg[31:0]  : acc[31:0];
    end else if (b_zero) begin
      fix_hi = orig_a;
      fix_lo = '1;
    end else begin
      fix_hi = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
      fix_lo = neg_q ? (~acc[31:0]  + 32'd1) : acc[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      orig_a  <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      b_zero  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      if (start_ok) begin
        state   <= S_CALC;
        cnt     <= '0;
        is_div  <= bus.funct[1];
        acc     <= bus.funct[1] ? {32'd0, a_abs} : {32'd0, b_abs};
        operand <= bus.funct[1] ? b_abs : a_abs;
        orig_a  <= bus.op_a;
        neg_q   <= in_signed && (bus.op_a[31] ^ bus.op_b[31]);
        neg_r   <= in_signed && bus.op_a[31];
        b_zero  <= (bus.op_b == 32'd0);
      end else begin
        case (state)
          S_CALC: begin
            if (is_div) begin
              if (!alu_y[33]) acc <= {alu_y[31:0], acc[30:0], 1'b1};
              else            acc <= {acc[62:0], 1'b0};
            end else begin
              if (acc[0]) acc <= {alu_y[32:0], acc[31:1]};
              else        acc <= {1'b0, acc[63:1]};
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= S_FIX;
          end
          S_FIX: begin
            hi_r  <= fix_hi;
            lo_r  <= fix_lo;
            state <= S_DONE;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy     = (state == S_CALC) || (state == S_FIX);
  assign bus.done     = (state == S_DONE);
  assign bus.div_zero = (state == S_DONE) && is_div && b_zero;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Present a request for one edge; returns #1 after that edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.funct = f;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called #1 after the start edge. Optionally pokes a DIVU start and a new
  // op_a at sample 'poke' to show they are ignored mid-operation.
  task automatic wait_done(input string tag, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dz, input int poke);
    int cycles;
    int busy_cnt;
    cycles   = 0;
    busy_cnt = 0;
    while (!bus.done && cycles < 100) begin
      if (bus.busy) busy_cnt++;
      if (cycles == poke) begin
        bus.start = 1'b1;
        bus.funct = F_DIVU;
        bus.op_a  = 32'd100;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    bus.start = 1'b0;
    check({tag, ".latency"}, 32'(cycles), 32'd33);
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd33);
    check({tag, ".hi"}, bus.hi, exp_hi);
    check({tag, ".lo"}, bus.lo, exp_lo);
    check({tag, ".div_zero"}, {31'd0, bus.div_zero}, {31'd0, exp_dz});
  endtask

  task automatic done_drops(input string tag);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, ".idle_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int done_seen;
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.funct = '0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst.hi", bus.hi, 32'd0);
    check("rst.lo", bus.lo, 32'd0);
    check("rst.busy", {31'd0, bus.busy}, 32'd0);
    check("rst.done", {31'd0, bus.done}, 32'd0);
    check("rst.div_zero", {31'd0, bus.div_zero}, 32'd0);
    @(posedge clk);
    #1;

    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0, -1);
    done_drops("multu_max");

    issue(F_MULT, 32'hFFFFFFFD, 32'h00000005);
    wait_done("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, -1);
    done_drops("mult_neg");

    issue(F_MULT, 32'h80000000, 32'h80000000);
    wait_done("mult_min", 32'h40000000, 32'h00000000, 1'b0, -1);
    done_drops("mult_min");

    issue(F_DIVU, 32'd100, 32'd7);
    wait_done("divu_100_7", 32'd2, 32'd14, 1'b0, -1);
    done_drops("divu_100_7");

    issue(F_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, -1);
    done_drops("div_m7_2");

    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", 32'h00000000, 32'h80000000, 1'b0, -1);
    done_drops("div_ovf");

    issue(F_DIVU, 32'h12345678, 32'd0);
    wait_done("divu_zero", 32'h12345678, 32'hFFFFFFFF, 1'b1, -1);
    // Back-to-back: start sampled in the DONE cycle.
    issue(F_DIVU, 32'd10, 32'd3);
    check("b2b.done_drop", {31'd0, bus.done}, 32'd0);
    check("b2b.busy_rise", {31'd0, bus.busy}, 32'd1);
    wait_done("divu_10_3", 32'd1, 32'd3, 1'b0, -1);
    done_drops("divu_10_3");

    issue(F_MULTU, 32'd2, 32'd3);
    wait_done("start_ignored", 32'd0, 32'd6, 1'b0, 5);
    done_drops("start_ignored");

    issue(6'b100000, 32'd5, 32'd5);
    check("bad_funct.busy0", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bad_funct.busy", {31'd0, bus.busy}, 32'd0);
    check("bad_funct.hi", bus.hi, 32'd0);
    check("bad_funct.lo", bus.lo, 32'd6);

    issue(F_MULT, 32'd123, 32'd456);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst.hi", bus.hi, 32'd0);
    check("mid_rst.lo", bus.lo, 32'd0);
    check("mid_rst.busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) done_seen++;
    end
    check("mid_rst.no_done", 32'(done_seen), 32'd0);

    issue(F_MULT, 32'd7, 32'd6);
    wait_done("mult_7_6", 32'd0, 32'd42, 1'b0, -1);
    done_drops("mult_7_6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
